// File: rtl/axil_reg_wr_demux.sv
// AXI-Lite write front end: decodes AW into CH_COUNT register windows, one-hot write strobes,
// B responses queued in a small FIFO. Define AXIL_REG_WR_TIMEOUT_EN to build the ack timeout / SLVERR path.
//
// state  | meaning
// IDLE   | wait for held AW+W and FIFO room; decode, then issue or answer DECERR
// ACCESS | reg_wr_en[ch] high until the channel acks (or the timeout expires)
`timescale 1ns/1ps
module axil_reg_wr_demux #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int CH_COUNT      = 4,
    parameter int CH_ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int TIMEOUT       = 16,
    parameter int RESP_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_WIDTH-1:0]    s_axil_awaddr,
    input  logic [2:0]               s_axil_awprot,
    input  logic                     s_axil_awvalid,
    output logic                     s_axil_awready,
    input  logic [DATA_WIDTH-1:0]    s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]    s_axil_wstrb,
    input  logic                     s_axil_wvalid,
    output logic                     s_axil_wready,
    output logic [1:0]               s_axil_bresp,
    output logic                     s_axil_bvalid,
    input  logic                     s_axil_bready,
    output logic [CH_ADDR_WIDTH-1:0] reg_wr_addr,
    output logic [DATA_WIDTH-1:0]    reg_wr_data,
    output logic [STRB_WIDTH-1:0]    reg_wr_strb,
    output logic [CH_COUNT-1:0]      reg_wr_en,
    input  logic [CH_COUNT-1:0]      reg_wr_wait,
    input  logic [CH_COUNT-1:0]      reg_wr_ack,
    output logic [15:0]              wr_err_count
);

    localparam int CH_BITS = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;
    localparam int PTR_W   = $clog2(RESP_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    state_t                  state_q, state_d;
    logic                    aw_held_q, aw_held_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic                    w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic [CH_BITS-1:0]      ch_q, ch_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]          count_q, count_d;
    logic [1:0]              fifo_q [RESP_DEPTH];
    logic [1:0]              fifo_d [RESP_DEPTH];
    logic [15:0]             err_q, err_d;

    logic                    push, pop, rel_hold, unmapped, sel_ack;
    logic [1:0]              push_resp;
    logic [ADDR_WIDTH-1:0]   off;
    logic [CH_BITS-1:0]      dec_ch;
    logic                    unused_ok;

`ifdef AXIL_REG_WR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_wait;
    assign sel_wait  = reg_wr_wait[ch_q];
    assign unused_ok = ^s_axil_awprot;
`else
    localparam int unused_timeout = TIMEOUT;
    assign unused_ok = ^{s_axil_awprot, reg_wr_wait};
`endif

    // BASE_ADDR is window-aligned, so off's low bits equal the in-window offset.
    always_comb begin
        off      = awaddr_q - BASE_ADDR;
        dec_ch   = off[CH_ADDR_WIDTH +: CH_BITS];
        unmapped = (awaddr_q < BASE_ADDR) ||
                   ((off >> CH_ADDR_WIDTH) >= ADDR_WIDTH'(CH_COUNT));
    end

    assign sel_ack = reg_wr_ack[ch_q];

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        push      = 1'b0;
        push_resp = RESP_OKAY;
        rel_hold  = 1'b0;
`ifdef AXIL_REG_WR_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (aw_held_q && w_held_q && (count_q < (PTR_W+1)'(RESP_DEPTH))) begin
                    if (unmapped) begin
                        push      = 1'b1;
                        push_resp = RESP_DECERR;
                        rel_hold  = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                        ch_d    = dec_ch;
`ifdef AXIL_REG_WR_TIMEOUT_EN
                        cnt_d   = CNT_W'(TIMEOUT - 1);
`endif
                    end
                end
            end
            ST_ACCESS: begin
                if (sel_ack) begin
                    push     = 1'b1;
                    rel_hold = 1'b1;
                    state_d  = ST_IDLE;
                end
`ifdef AXIL_REG_WR_TIMEOUT_EN
                else if (!sel_wait) begin
                    if (cnt_q == '0) begin
                        push      = 1'b1;
                        push_resp = RESP_SLVERR;
                        rel_hold  = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        if (rel_hold) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end else begin
            if (s_axil_awvalid && !aw_held_q) begin
                aw_held_d = 1'b1;
                awaddr_d  = s_axil_awaddr;
            end
            if (s_axil_wvalid && !w_held_q) begin
                w_held_d = 1'b1;
                wdata_d  = s_axil_wdata;
                wstrb_d  = s_axil_wstrb;
            end
        end
    end

    always_comb begin
        pop      = (count_q != '0) && s_axil_bready;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        if (push) begin
            fifo_d[wr_ptr_q] = push_resp;
            wr_ptr_d         = wr_ptr_q + 1'b1;
            if ((push_resp != RESP_OKAY) && (err_q != 16'hFFFF)) begin
                err_d = err_q + 16'd1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            aw_held_q <= 1'b0;
            awaddr_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            ch_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
`ifdef AXIL_REG_WR_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            aw_held_q <= aw_held_d;
            awaddr_q  <= awaddr_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            ch_q      <= ch_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
            fifo_q    <= fifo_d;
`ifdef AXIL_REG_WR_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign s_axil_awready = !aw_held_q;
    assign s_axil_wready  = !w_held_q;
    assign s_axil_bvalid  = (count_q != '0);
    assign s_axil_bresp   = fifo_q[rd_ptr_q];
    assign wr_err_count   = err_q;

    always_comb begin
        reg_wr_en   = '0;
        reg_wr_addr = '0;
        reg_wr_data = '0;
        reg_wr_strb = '0;
        if (state_q == ST_ACCESS) begin
            reg_wr_en[ch_q] = 1'b1;
            reg_wr_addr     = off[CH_ADDR_WIDTH-1:0];
            reg_wr_data     = wdata_q;
            reg_wr_strb     = wstrb_q;
        end
    end

endmodule

// File: tb/tb_axil_reg_wr_demux.sv
// Directed bench for axil_reg_wr_demux: table-driven single writes plus hand sequences for
// channel ordering, B backpressure, ack timeout (or indefinite wait) and mid-access reset.
`timescale 1ns/1ps
module tb_axil_reg_wr_demux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_axil_awaddr = '0;
    logic [2:0]  s_axil_awprot = '0;
    logic        s_axil_awvalid = 1'b0;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata = '0;
    logic [3:0]  s_axil_wstrb = '0;
    logic        s_axil_wvalid = 1'b0;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready = 1'b1;
    logic [7:0]  reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic [3:0]  reg_wr_strb;
    logic [3:0]  reg_wr_en;
    logic [3:0]  reg_wr_wait = '0;
    logic [3:0]  reg_wr_ack = '0;
    logic [15:0] wr_err_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_err = 0;

    always #5 clk = ~clk;

    axil_reg_wr_demux dut (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
        .reg_wr_en(reg_wr_en), .reg_wr_wait(reg_wr_wait), .reg_wr_ack(reg_wr_ack),
        .wr_err_count(wr_err_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          ack_after;
        logic [3:0]  exp_en;
        logic [7:0]  exp_addr;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_aw(input logic [31:0] a);
        int k = 0;
        s_axil_awaddr  = a;
        s_axil_awvalid = 1'b1;
        while (!s_axil_awready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("aw_handshake", 64'(k < 50), 64'd1);
        @(negedge clk);
        s_axil_awvalid = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
        int k = 0;
        s_axil_wdata  = d;
        s_axil_wstrb  = s;
        s_axil_wvalid = 1'b1;
        while (!s_axil_wready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("w_handshake", 64'(k < 50), 64'd1);
        @(negedge clk);
        s_axil_wvalid = 1'b0;
    endtask

    // Entered on the negedge of the cycle after the last handshake.
    task automatic run_access(input logic [3:0] exp_en, input logic [7:0] exp_addr,
                              input logic [31:0] exp_data, input logic [3:0] exp_strb,
                              input int ack_after, input bit chk_lat);
        int lat = 0;
        int en_cycles = 1;
        while (reg_wr_en == '0 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (chk_lat) check("en_latency", 64'(lat), 64'd1);
        check("en_onehot", 64'(reg_wr_en), 64'(exp_en));
        check("wr_addr", 64'(reg_wr_addr), 64'(exp_addr));
        check("wr_data", 64'(reg_wr_data), 64'(exp_data));
        check("wr_strb", 64'(reg_wr_strb), 64'(exp_strb));
        for (int i = 0; i < ack_after; i++) begin
            @(negedge clk);
            if (reg_wr_en == exp_en) en_cycles++;
        end
        reg_wr_ack = exp_en;
        @(negedge clk);
        reg_wr_ack = '0;
        check("en_after_ack", 64'(reg_wr_en), 64'd0);
        check("en_pulse_len", 64'(en_cycles), 64'(ack_after + 1));
    endtask

    task automatic check_resp(input logic [1:0] exp);
        int k = 0;
        while (!s_axil_bvalid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("bvalid_wait", 64'(k < 40), 64'd1);
        check("bresp", 64'(s_axil_bresp), 64'(exp));
        if (exp != 2'b00) exp_err++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int k;

        vecs[0] = '{32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 1, 4'b0010, 8'h04, 2'b00};
        vecs[1] = '{32'h0000_0000, 32'h1234_5678, 4'h1, 0, 4'b0001, 8'h00, 2'b00};
        vecs[2] = '{32'h0000_02FC, 32'hA5A5_A5A5, 4'h0, 2, 4'b0100, 8'hFC, 2'b00};
        vecs[3] = '{32'h0000_03FF, 32'h0BAD_F00D, 4'h8, 0, 4'b1000, 8'hFF, 2'b00};
        vecs[4] = '{32'h0000_0400, 32'h1111_1111, 4'hF, 0, 4'b0000, 8'h00, 2'b11};
        vecs[5] = '{32'hFFFF_FFFC, 32'h2222_2222, 4'hF, 0, 4'b0000, 8'h00, 2'b11};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'({s_axil_awready, s_axil_wready}), 64'b11);
        check("rst_bvalid", 64'(s_axil_bvalid), 64'd0);
        check("rst_bresp", 64'(s_axil_bresp), 64'd0);
        check("rst_en", 64'(reg_wr_en), 64'd0);
        check("rst_outs", 64'(|{reg_wr_addr, reg_wr_data, reg_wr_strb}), 64'd0);
        check("rst_err", 64'(wr_err_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            fork
                drive_aw(vecs[i].addr);
                drive_w(vecs[i].data, vecs[i].strb);
            join
            if (vecs[i].exp_en != '0) begin
                run_access(vecs[i].exp_en, vecs[i].exp_addr, vecs[i].data, vecs[i].strb,
                           vecs[i].ack_after, 1'b1);
                check("ready_after_ack", 64'({s_axil_awready, s_axil_wready}), 64'b11);
                check("bvalid_after_ack", 64'(s_axil_bvalid), 64'd1);
            end else begin
                check("decerr_no_en_a", 64'(reg_wr_en), 64'd0);
                @(negedge clk);
                check("decerr_latency", 64'(s_axil_bvalid), 64'd1);
                check("decerr_no_en_b", 64'(reg_wr_en), 64'd0);
                check("decerr_ready", 64'({s_axil_awready, s_axil_wready}), 64'b11);
            end
            check_resp(vecs[i].exp_resp);
            check("bvalid_drained", 64'(s_axil_bvalid), 64'd0);
        end
        check("err_count_table", 64'(wr_err_count), 64'(exp_err));

        // AW three cycles ahead of W
        drive_aw(32'h0000_0208);
        check("awfirst_awready", 64'(s_axil_awready), 64'd0);
        check("awfirst_wready", 64'(s_axil_wready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        check("awfirst_hold", 64'({s_axil_awready, reg_wr_en}), 64'd0);
        drive_w(32'h1122_3344, 4'h3);
        run_access(4'b0100, 8'h08, 32'h1122_3344, 4'h3, 0, 1'b1);
        check("awfirst_ready_back", 64'({s_axil_awready, s_axil_wready}), 64'b11);
        check_resp(2'b00);

        // W ahead of AW
        drive_w(32'h5566_7788, 4'hC);
        check("wfirst_wready", 64'(s_axil_wready), 64'd0);
        check("wfirst_awready", 64'(s_axil_awready), 64'd1);
        @(negedge clk);
        drive_aw(32'h0000_030C);
        run_access(4'b1000, 8'h0C, 32'h5566_7788, 4'hC, 0, 1'b1);
        check("wfirst_ready_back", 64'({s_axil_awready, s_axil_wready}), 64'b11);
        check_resp(2'b00);

`ifdef AXIL_REG_WR_TIMEOUT_EN
        fork
            drive_aw(32'h0000_0200);
            drive_w(32'hCAFE_0001, 4'hF);
        join
        reg_wr_ack  = 4'b1011;
        reg_wr_wait = 4'b1011;
        k = 0;
        while (reg_wr_en == '0 && k < 10) begin @(negedge clk); k++; end
        cnt = 0;
        while (reg_wr_en[2] && cnt < 100) begin cnt++; @(negedge clk); end
        reg_wr_ack  = '0;
        reg_wr_wait = '0;
        check("timeout_en_cycles", 64'(cnt), 64'd16);
        check_resp(2'b10);

        fork
            drive_aw(32'h0000_0210);
            drive_w(32'hCAFE_0002, 4'hF);
        join
        k = 0;
        while (reg_wr_en == '0 && k < 10) begin @(negedge clk); k++; end
        cnt = 0;
        while (reg_wr_en[2] && cnt < 100) begin
            cnt++;
            reg_wr_wait = (cnt >= 3 && cnt < 13) ? 4'b0100 : 4'b0000;
            @(negedge clk);
        end
        reg_wr_wait = '0;
        check("timeout_wait_en_cycles", 64'(cnt), 64'd26);
        check_resp(2'b10);
`else
        fork
            drive_aw(32'h0000_0200);
            drive_w(32'hCAFE_0001, 4'hF);
        join
        reg_wr_ack  = 4'b1011;
        reg_wr_wait = 4'b1111;
        k = 0;
        while (reg_wr_en == '0 && k < 10) begin @(negedge clk); k++; end
        cnt = 0;
        while (reg_wr_en[2] && cnt < 40) begin cnt++; @(negedge clk); end
        check("no_timeout_en_held", 64'(cnt), 64'd40);
        check("no_timeout_no_resp", 64'(s_axil_bvalid), 64'd0);
        reg_wr_ack = 4'b0100;
        @(negedge clk);
        reg_wr_ack  = '0;
        reg_wr_wait = '0;
        check("no_timeout_en_drop", 64'(reg_wr_en), 64'd0);
        check_resp(2'b00);
`endif
        check("err_count_after_to", 64'(wr_err_count), 64'(exp_err));

        // B backpressure: four responses fill the FIFO, the fifth write stalls
        s_axil_bready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fork
                drive_aw(32'h0000_0100 + 32'(i * 4));
                drive_w(32'h0000_1000 + 32'(i), 4'hF);
            join
            run_access(4'b0010, 8'(i * 4), 32'h0000_1000 + 32'(i), 4'hF, 0, 1'b1);
        end
        fork
            drive_aw(32'h0000_0110);
            drive_w(32'h0000_1004, 4'hF);
        join
        for (int i = 0; i < 4; i++) begin
            check("bp_stall_en", 64'(reg_wr_en), 64'd0);
            check("bp_stall_awready", 64'(s_axil_awready), 64'd0);
            @(negedge clk);
        end
        s_axil_bready = 1'b1;
        fork
            begin : collector
                int got;
                int kk;
                got = 0;
                kk = 0;
                while (got < 6 && kk < 200) begin
                    if (s_axil_bvalid) begin
                        check("bp_bresp", 64'(s_axil_bresp), 64'd0);
                        got++;
                    end
                    @(negedge clk);
                    kk++;
                end
                check("bp_resp_count", 64'(got), 64'd6);
            end
            begin : writer
                run_access(4'b0010, 8'h10, 32'h0000_1004, 4'hF, 0, 1'b0);
                fork
                    drive_aw(32'h0000_0114);
                    drive_w(32'h0000_1005, 4'hF);
                join
                run_access(4'b0010, 8'h14, 32'h0000_1005, 4'hF, 0, 1'b0);
            end
        join
        check("bp_drained", 64'(s_axil_bvalid), 64'd0);

        // Reset mid-access with a DECERR still queued
        s_axil_bready = 1'b0;
        fork
            drive_aw(32'h0000_0800);
            drive_w(32'h0000_0000, 4'hF);
        join
        exp_err++;
        @(negedge clk);
        check("pre_rst_bvalid", 64'(s_axil_bvalid), 64'd1);
        check("pre_rst_err", 64'(wr_err_count), 64'(exp_err));
        fork
            drive_aw(32'h0000_0100);
            drive_w(32'h55AA_55AA, 4'hF);
        join
        k = 0;
        while (reg_wr_en == '0 && k < 10) begin @(negedge clk); k++; end
        check("pre_rst_en", 64'(reg_wr_en), 64'b0010);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_en", 64'(reg_wr_en), 64'd0);
        check("rst_mid_bvalid", 64'(s_axil_bvalid), 64'd0);
        check("rst_mid_ready", 64'({s_axil_awready, s_axil_wready}), 64'b11);
        check("rst_mid_err", 64'(wr_err_count), 64'd0);
        exp_err = 0;
        s_axil_bready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fork
            drive_aw(32'h0000_0104);
            drive_w(32'h0F0F_0F0F, 4'hF);
        join
        run_access(4'b0010, 8'h04, 32'h0F0F_0F0F, 4'hF, 0, 1'b1);
        check_resp(2'b00);
        check("post_rst_drained", 64'(s_axil_bvalid), 64'd0);
        check("post_rst_err", 64'(wr_err_count), 64'(exp_err));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
